burst_addr_gen: RTL and testbench

- Parametrised successor to the single/burst serial address controller.
- Deserialises an initial address and a burst length, then re-serialises one address frame per beat to the STP/PTS address mux.
- Steps the address each beat (INCR, optional WRAP) and paces beats with a downstream `next` handshake.
- Sits between the host-side serial command inputs and the serial address path of the MRAM STP/PTS module.

---
 rtl/burst_addr_gen.sv | 133 +++++++++++++
 tb/tb_burst_addr_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_addr_gen.sv
// Burst address generator: deserialises a start address and burst length, then emits one
// MSB-first address frame per beat. Define BURST_WRAP_EN to add wrap_sel_i and WRAP stepping.
module burst_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic burst_en_i,
  input  logic mode_sel_i,
`ifdef BURST_WRAP_EN
  input  logic wrap_sel_i,
`endif
  input  logic burst_len_in_i,
  input  logic addr_in_i,
  input  logic next_i,
  output logic addr_sel_o,
  output logic addr_ser_out_o,
  output logic busy_o,
  output logic done_o
);
  localparam int            CW   = $clog2(ADDR_W);
  localparam logic [CW-1:0] LAST = CW'(ADDR_W - 1);
  localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q, step_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    left_q, beats_d;
  logic              addr_sel_q, ser_q, busy_q, done_q;
`ifdef BURST_WRAP_EN
  logic [LEN_W:0]    beats_q;
  logic              wrap_q;
  logic [ADDR_W-1:0] mask;
`endif

  // Length bits arrive only on the first LEN_W load edges.
  always_comb begin
    len_d   = (int'(cnt_q) < LEN_W) ? LEN_W'({len_q, burst_len_in_i}) : len_q;
    beats_d = mode_sel_i ? ((LEN_W+1)'(len_d) + ONE) : ONE;
  end

  always_comb begin
    step_d = addr_q + ADDR_W'(1);
`ifdef BURST_WRAP_EN
    mask = ADDR_W'(beats_q - ONE);
    if (wrap_q && ((beats_q & (beats_q - ONE)) == '0))
      step_d = (addr_q & ~mask) | (step_d & mask);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      left_q     <= '0;
      addr_sel_q <= 1'b0;
      ser_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BURST_WRAP_EN
      beats_q    <= '0;
      wrap_q     <= 1'b0;
`endif
    end else begin
      addr_sel_q <= 1'b0;
      ser_q      <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: if (burst_en_i) begin
          state_q <= LOAD;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        LOAD: if (!burst_en_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          addr_q <= ADDR_W'({addr_q, addr_in_i});
          len_q  <= len_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            left_q  <= beats_d;
`ifdef BURST_WRAP_EN
            beats_q <= beats_d;
            wrap_q  <= wrap_sel_i;
`endif
            state_q <= SEND;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SEND: if (!burst_en_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          addr_sel_q <= 1'b1;
          ser_q      <= addr_q[LAST - cnt_q];
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            left_q  <= left_q - ONE;
            state_q <= (left_q == ONE) ? DONE : WAIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT: if (!burst_en_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (next_i) begin
          addr_q  <= step_d;
          state_q <= SEND;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_sel_o     = addr_sel_q;
  assign addr_ser_out_o = ser_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
endmodule

// File: tb/tb_burst_addr_gen.sv
// Bench for burst_addr_gen: a timeline model predicts every output on every cycle from the
// transaction plan; captured frames are also pinned against hand-computed address lists.
module tb_burst_addr_gen;
  localparam int AW = 8, LW = 4, MAXC = 40000;
  typedef logic [AW-1:0] fq_t[$];

  logic clk = 0, rst_n = 0, burst_en = 0, mode_sel = 0, wrap_sel = 0;
  logic len_in = 0, addr_in = 0, nxt = 0;
  logic addr_sel, ser, busy, done;
  int   cyc = 0, checks = 0, errors = 0;
  bit   e_sel[MAXC], e_ser[MAXC], e_busy[MAXC], e_done[MAXC];
  fq_t  cap_q;
  logic [AW-1:0] sh = '0;
  int   nb = 0, done_cnt = 0, first_sel = -1;
  logic prev_sel = 0;

  burst_addr_gen #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .burst_en_i(burst_en), .mode_sel_i(mode_sel),
`ifdef BURST_WRAP_EN
    .wrap_sel_i(wrap_sel),
`endif
    .burst_len_in_i(len_in), .addr_in_i(addr_in), .next_i(nxt),
    .addr_sel_o(addr_sel), .addr_ser_out_o(ser), .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-by-cycle compare against the predicted timeline, plus frame capture.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      checks++;
      if ({addr_sel, ser, busy, done} !== {e_sel[cyc], e_ser[cyc], e_busy[cyc], e_done[cyc]}) begin
        errors++;
        if (errors <= 30)
          $display("FAIL cycle %0d sel/ser/busy/done got %b%b%b%b want %b%b%b%b", cyc,
                   addr_sel, ser, busy, done, e_sel[cyc], e_ser[cyc], e_busy[cyc], e_done[cyc]);
      end
      if (addr_sel === 1'b1) begin
        if (prev_sel !== 1'b1 && first_sel < 0) first_sel = cyc;
        sh = {sh[AW-2:0], ser};
        nb++;
        if (nb == AW) begin cap_q.push_back(sh); nb = 0; end
      end else nb = 0;
      prev_sel = addr_sel;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic chk_frames(input string name, input fq_t exp, input int exp_done);
    chk({name, " frames"}, cap_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++) chk({name, " addr"}, cap_q[i], exp[i]);
    chk({name, " done"}, done_cnt, exp_done);
    cap_q.delete();
    done_cnt = 0;
  endtask

  // Address sequence rule: INCR modulo 2^AW, or wrap inside an aligned power-of-two block.
  function automatic logic [AW-1:0] step_m(input logic [AW-1:0] a, input int beats, input bit wrap);
    int base;
    if (wrap && (beats & (beats - 1)) == 0) begin
      base = int'(a) - (int'(a) % beats);
      return AW'(base + ((int'(a) - base + 1) % beats));
    end
    return AW'((int'(a) + 1) % (1 << AW));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    burst_en = 0;
    repeat (n) begin
      nxt = 1'($urandom); addr_in = 1'($urandom); len_in = 1'($urandom);
      tick();
    end
  endtask

  // cut_kind: 0 none, 1 burst_en dropped at edge e0+cut_rel, 2 reset at that edge (cut_rel<=0: random).
  task automatic txn(input logic [AW-1:0] addr, input logic [LW-1:0] len, input bit mode,
                     input bit wrap, input int dmax, input int cut_kind, input int cut_rel);
    int e0, beats, cut, dend, last, idx, c;
    int d[$], f[$];
    logic [AW-1:0] a;
    bit wr;
    e0 = cyc + 1;
    beats = mode ? int'(len) + 1 : 1;
    wr = 1'b0;
`ifdef BURST_WRAP_EN
    wr = wrap;
`endif
    for (int k = 0; k < beats; k++) d.push_back(int'($urandom_range(dmax, 0)));
    f.push_back(e0 + AW + 1);
    for (int k = 1; k < beats; k++) f.push_back(f[k-1] + AW + 1 + d[k-1]);
    dend = f[beats-1] + AW;
    if (cut_kind != 0 && cut_rel <= 0) cut_rel = int'($urandom_range(dend - e0 - 1, 1));
    cut  = (cut_kind != 0) ? e0 + cut_rel : dend + 1;
    last = (cut_kind != 0) ? cut : dend;
    if (last + 2 >= MAXC) begin
      errors++;
      $display("FAIL cycle budget exhausted at %0d", cyc);
      return;
    end
    for (c = e0; c < dend && c < cut; c++) e_busy[c] = 1'b1;
    a = addr;
    for (int k = 0; k < beats; k++) begin
      for (int i = 0; i < AW; i++) begin
        c = f[k] + i;
        if (c < cut) begin e_sel[c] = 1'b1; e_ser[c] = a[AW-1-i]; end
      end
      a = step_m(a, beats, wr);
    end
    if (cut_kind == 0) e_done[dend] = 1'b1;
    mode_sel = mode;
    wrap_sel = wrap;
    for (int e = e0; e <= last; e++) begin
      burst_en = 1;
      idx = e - e0 - 1;
      if (idx >= 0 && idx < AW) begin
        addr_in = addr[AW-1-idx];
        len_in  = (idx < LW) ? len[LW-1-idx] : 1'($urandom);
      end else begin
        addr_in = 1'($urandom);
        len_in  = 1'($urandom);
      end
      nxt = 1'($urandom);
      for (int k = 0; k < beats - 1; k++)
        if (e >= f[k] + AW && e <= f[k] + AW + d[k]) nxt = (e == f[k] + AW + d[k]);
      if (e == cut) begin
        burst_en = 0;
        if (cut_kind == 2) rst_n = 0;
      end
      tick();
    end
    rst_n = 1;
  endtask

  initial begin
    fq_t ex;
    int  e0s;
    repeat (3) tick();
    chk("reset addr_sel", int'(addr_sel), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst_n = 1;
    idle(2);

    // Single transfer: length ignored, one frame, 9-cycle latency.
    e0s = cyc + 1;
    txn(8'hA5, 4'hF, 1'b0, 1'b0, 0, 0, 0);
    idle(2);
    chk("single latency", first_sel - e0s, AW + 1);
    ex = {8'hA5};
    chk_frames("single", ex, 1);

    txn(8'h10, 4'd3, 1'b1, 1'b0, 2, 0, 0);
    idle(2);
    ex = {8'h10, 8'h11, 8'h12, 8'h13};
    chk_frames("incr", ex, 1);

    txn(8'hFE, 4'd2, 1'b1, 1'b0, 1, 0, 0);
    idle(2);
    ex = {8'hFE, 8'hFF, 8'h00};
    chk_frames("rollover", ex, 1);

`ifdef BURST_WRAP_EN
    txn(8'h0E, 4'd3, 1'b1, 1'b1, 1, 0, 0);
    idle(2);
    ex = {8'h0E, 8'h0F, 8'h0C, 8'h0D};
    chk_frames("wrap4", ex, 1);
    txn(8'h0E, 4'd2, 1'b1, 1'b1, 1, 0, 0);
    idle(2);
    ex = {8'h0E, 8'h0F, 8'h10};
    chk_frames("wrap3", ex, 1);
`endif

    // Abort while bit 3 of the second frame is on the line.
    txn(8'h40, 4'd3, 1'b1, 1'b0, 0, 1, 2 * AW + 6);
    idle(2);
    ex = {8'h40};
    chk_frames("abort", ex, 0);
    txn(8'h33, 4'd1, 1'b1, 1'b0, 0, 0, 0);
    idle(2);
    ex = {8'h33, 8'h34};
    chk_frames("restart", ex, 1);

    // Reset mid-load, then next pulses while idle.
    txn(8'h77, 4'd5, 1'b1, 1'b0, 0, 2, 4);
    idle(8);
    ex = {};
    chk_frames("reset mid-load", ex, 0);

    // Back-to-back with burst_en held across done.
    txn(8'h20, 4'd1, 1'b1, 1'b0, 0, 0, 0);
    txn(8'h80, 4'd0, 1'b1, 1'b0, 0, 0, 0);
    idle(2);
    ex = {8'h20, 8'h21, 8'h80};
    chk_frames("back-to-back", ex, 2);

    for (int t = 0; t < 30; t++) begin
      int r;
      r = int'($urandom_range(9, 0));
      txn(AW'($urandom), LW'($urandom), 1'($urandom), 1'($urandom), 3,
          (r == 0) ? 2 : (r < 3) ? 1 : 0, 0);
      idle(int'($urandom_range(2, 0)));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
